btb_plru: RTL

Replacement-state unit for the branch target buffer. It holds one tree pseudo-LRU record per BTB set for any power-of-two associativity, and applies touches from the lookup (read-hit) port and the allocate/update (write) port. It presents the victim way for a queried set and runs a multi-cycle flush sweep that clears all records. It sits beside the BTB tag/target arrays in the IF stage and generalises the earlier single-bit, 2-way LRU next-state logic.

---
 rtl/btb_pkg.sv | 21 ++
 rtl/btb_plru_tree.sv | 57 +++++
 rtl/btb_plru.sv | 131 +++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared pseudo-LRU constants and types for the BTB replacement-state unit.
// Latency: n/a (package only, no logic).
// Backpressure: n/a.
// Contents: tree node-count helper, left/right node encoding, flush FSM states.
package btb_pkg;

  // A node bit names the subtree that holds the victim.
  localparam logic PLRU_LEFT  = 1'b0;
  localparam logic PLRU_RIGHT = 1'b1;

  // A binary tree over WAYS leaves has WAYS-1 internal nodes.
  function automatic int plru_nodes(input int ways);
    return ways - 1;
  endfunction

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_SWEEP = 1'b1
  } flush_state_e;

endpackage

// File: rtl/btb_plru_tree.sv
// Tree pseudo-LRU helper: applies one touch to a record and decodes its victim way.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs every cycle.
// Ports: bits_i record in, touch_en_i/touch_way_i touch request, bits_o updated record,
//        victim_o leaf reached by following bits_i from the root.
module plru_tree
  import btb_pkg::*;
#(
  parameter  int WAYS  = 2,
  localparam int WAY_W = $clog2(WAYS),
  localparam int NODES = plru_nodes(WAYS)
) (
  input  logic [NODES-1:0] bits_i,
  input  logic             touch_en_i,
  input  logic [WAY_W-1:0] touch_way_i,
  output logic [NODES-1:0] bits_o,
  output logic [WAY_W-1:0] victim_o
);

  // Update: node k sits at depth D and covers the ways whose top D bits equal
  // its position within that level. Nodes on the touched way's path point away
  // from it, i.e. toward the half that does not contain the way.
  for (genvar k = 0; k < NODES; k++) begin : g_node
    localparam int D   = $clog2(k + 2) - 1;
    localparam int POS = k + 1 - (1 << D);
    logic on_path;
    if (D == 0) begin : g_root
      assign on_path = 1'b1;
    end else begin : g_inner
      assign on_path = (touch_way_i >> (WAY_W - D)) == WAY_W'(POS);
    end
    assign bits_o[k] = (touch_en_i && on_path)
                     ? (touch_way_i[WAY_W-1-D] ? PLRU_LEFT : PLRU_RIGHT)
                     : bits_i[k];
  end

  // Victim: leaf w is reached only if every node on its path steers toward it,
  // so exactly one leaf_hit bit is set for any record value.
  logic [WAYS-1:0] leaf_hit;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [WAY_W-1:0] match;
    for (genvar l = 0; l < WAY_W; l++) begin : g_lvl
      localparam int   N   = (1 << l) - 1 + (w >> (WAY_W - l));
      localparam logic DIR = 1'((w >> (WAY_W - 1 - l)) & 1);
      assign match[l] = (bits_i[N] == DIR);
    end
    assign leaf_hit[w] = &match;
  end

  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (leaf_hit[w]) victim_o = WAY_W'(w);
    end
  end

endmodule

// File: rtl/btb_plru.sv
// BTB replacement state: one tree pseudo-LRU record per set, read/write touches, victim query, flush sweep.
// Latency: touches land at the next edge; vic_way_o is combinational from vic_index_i (registered state by default).
// Backpressure: none; while busy_o is high (SETS-cycle flush sweep) touches and flush requests are dropped.
// Ports: clk_i/rst_n_i clock and async active-low reset; rd_*_i lookup-hit touch; wr_*_i allocate touch;
//        vic_index_i/vic_way_o victim query; flush_i sweep request; busy_o sweep in progress.
// Option: define BTB_PLRU_FWD_EN to compute vic_way_o from the next-state record (same-cycle touches visible).
module btb_plru
  import btb_pkg::*;
#(
  parameter  int SETS  = 8,
  parameter  int WAYS  = 2,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_index_i,
  input  logic [WAY_W-1:0] rd_way_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_index_i,
  input  logic [WAY_W-1:0] wr_way_i,
  input  logic [IDX_W-1:0] vic_index_i,
  output logic [WAY_W-1:0] vic_way_o,
  input  logic             flush_i,
  output logic             busy_o
);

  localparam int NODES = plru_nodes(WAYS);

  flush_state_e     state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             busy_q;
  logic [NODES-1:0] rec_q [SETS];
  logic [NODES-1:0] rec_d [SETS];

  // A flush accepted this cycle wins over any touch presented with it.
  logic touch_ok, rd_touch, wr_touch;
  assign touch_ok = (state_q == FL_IDLE) && !flush_i;
  assign rd_touch = rd_en_i && touch_ok;
  assign wr_touch = wr_en_i && touch_ok;

  logic [NODES-1:0] rd_bits, wr_base, wr_bits, vq_bits, vq_bits_unused;
  logic [WAY_W-1:0] rd_vic_unused, wr_vic_unused;

  // Same-set rd+wr: the write touch is chained onto the read result so the
  // write (most recent) owns any shared nodes.
  assign wr_base = (rd_touch && (rd_index_i == wr_index_i)) ? rd_bits : rec_q[wr_index_i];

  plru_tree #(.WAYS(WAYS)) u_rd_tree (
    .bits_i      (rec_q[rd_index_i]),
    .touch_en_i  (rd_touch),
    .touch_way_i (rd_way_i),
    .bits_o      (rd_bits),
    .victim_o    (rd_vic_unused)
  );

  plru_tree #(.WAYS(WAYS)) u_wr_tree (
    .bits_i      (wr_base),
    .touch_en_i  (wr_touch),
    .touch_way_i (wr_way_i),
    .bits_o      (wr_bits),
    .victim_o    (wr_vic_unused)
  );

`ifdef BTB_PLRU_FWD_EN
  assign vq_bits = rec_d[vic_index_i];
`else
  assign vq_bits = rec_q[vic_index_i];
`endif

  plru_tree #(.WAYS(WAYS)) u_vic_tree (
    .bits_i      (vq_bits),
    .touch_en_i  (1'b0),
    .touch_way_i ('0),
    .bits_o      (vq_bits_unused),
    .victim_o    (vic_way_o)
  );

  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      rec_d[s] = rec_q[s];
      if (state_q == FL_SWEEP) begin
        if (cnt_q == IDX_W'(s)) rec_d[s] = '0;
      end else begin
        if (rd_touch && (rd_index_i == IDX_W'(s))) rec_d[s] = rd_bits;
        if (wr_touch && (wr_index_i == IDX_W'(s))) rec_d[s] = wr_bits;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SETS; s++) rec_q[s] <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) rec_q[s] <= rec_d[s];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= FL_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        FL_IDLE: begin
          if (flush_i) begin
            state_q <= FL_SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FL_SWEEP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IDX_W'(SETS - 1)) begin
            state_q <= FL_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= FL_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;

endmodule
